char_buf_score: RTL and testbench



---
 rtl/char_buf_score.sv | 156 +++++++++++++++
 tb/tb_char_buf_score.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/char_buf_score.sv
// char_buf_score
// Writer-side character buffer for the on-screen score line "score" + value.
// Binary score updates are converted to decimal with a sequential double-dabble
// (one step per cycle), then the ASCII digits are written into the buffer one
// cell per cycle, most significant first, with leading zeros blanked.
// The read side matches the char ROMs: char_xy in, registered char_code out.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   score_in     binary score, sampled when score_valid=1 and busy=0
//   score_valid  one-cycle update request
//   busy         high while a conversion/write is in progress
//   update_done  one-cycle pulse when the new digits are fully in the buffer
//   char_xy      character index from the text renderer
//   char_code    ASCII code at char_xy, one cycle after the address
//
// Handshake: an update is accepted on a rising clk edge where score_valid=1
// and busy=0 (busy is registered, so it is the value seen in that cycle);
// requests while busy=1 are dropped, never queued.
module char_buf_score #(
  parameter int SCORE_W = 14,
  parameter int DIGITS  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               score_valid,
  output logic               busy,
  output logic               update_done,
  input  logic [11:0]        char_xy,
  output logic [6:0]         char_code
);

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          CNT_W   = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int          IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    WRITE   = 2'd2
  } state_t;

  state_t             state;
  logic [SCORE_W-1:0] bin;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   bit_cnt;
  logic [IDX_W-1:0]   dig_idx;
  logic               seen_nonzero;
  logic [6:0]         digit_buf [DIGITS];
  logic [SCORE_W-1:0] score_sat;
  logic [3:0]         cur_nib;
  logic [6:0]         cur_code;
  logic [6:0]         rd_code;

  // Saturate to the largest displayable value.
  always_comb begin
    score_sat = score_in;
    if (32'(score_in) > MAX_VAL) score_sat = SCORE_W'(MAX_VAL);
  end

  // Double-dabble correction: add 3 to every nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // The BCD register is shifted up by one nibble per write, so the digit to
  // write is always the top nibble. The last digit is never blanked.
  always_comb begin
    cur_nib  = bcd[BCD_W-1 -: 4];
    cur_code = 7'h30 | {3'b000, cur_nib};
    if (cur_nib == 4'd0 && !seen_nonzero && dig_idx != IDX_W'(DIGITS - 1))
      cur_code = 7'h20;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      update_done  <= 1'b0;
      bin          <= '0;
      bcd          <= '0;
      bit_cnt      <= '0;
      dig_idx      <= '0;
      seen_nonzero <= 1'b0;
      for (int i = 0; i < DIGITS; i++)
        digit_buf[i] <= (i == DIGITS - 1) ? 7'h30 : 7'h20;
    end else begin
      update_done <= 1'b0;
      case (state)
        IDLE: begin
          if (score_valid) begin
            bin     <= score_sat;
            bcd     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          bcd     <= {bcd_adj[BCD_W-2:0], bin[SCORE_W-1]};
          bin     <= {bin[SCORE_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(SCORE_W - 1)) begin
            dig_idx      <= '0;
            seen_nonzero <= 1'b0;
            state        <= WRITE;
          end
        end
        WRITE: begin
          digit_buf[dig_idx] <= cur_code;
          bcd                <= {bcd[BCD_W-5:0], 4'd0};
          seen_nonzero       <= seen_nonzero | (cur_nib != 4'd0);
          dig_idx            <= dig_idx + 1'b1;
          if (dig_idx == IDX_W'(DIGITS - 1)) begin
            busy        <= 1'b0;
            update_done <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Read mux: fixed label, separator blank, digit cells, blank elsewhere.
  always_comb begin
    rd_code = 7'h20;
    case (char_xy)
      12'h000: rd_code = 7'h73;  // s
      12'h001: rd_code = 7'h63;  // c
      12'h002: rd_code = 7'h6f;  // o
      12'h003: rd_code = 7'h72;  // r
      12'h004: rd_code = 7'h65;  // e
      default: begin
        if (char_xy >= 12'd6 && char_xy < 12'(6 + DIGITS))
          rd_code = digit_buf[IDX_W'(char_xy - 12'd6)];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) char_code <= 7'h20;
    else        char_code <= rd_code;
  end

endmodule

// File: tb/tb_char_buf_score.sv
module tb_char_buf_score;
  localparam int SCORE_W = 14;
  localparam int DIGITS  = 4;
  localparam int BUSY_CYCLES = SCORE_W + DIGITS;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [SCORE_W-1:0] score_in = '0;
  logic               score_valid = 1'b0;
  logic               busy;
  logic               update_done;
  logic [11:0]        char_xy = '0;
  logic [6:0]         char_code;

  int checks = 0;
  int errors = 0;
  int model_val = 0;
  logic [6:0] exp_q[$];

  char_buf_score #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .score_in(score_in), .score_valid(score_valid),
    .busy(busy), .update_done(update_done), .char_xy(char_xy), .char_code(char_code)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the displayed line computed from the value with plain arithmetic.
  function automatic logic [6:0] exp_char(input int a, input int val);
    string lbl = "score";
    int v, pos, p, d;
    v = (val > 9999) ? 9999 : val;
    if (a < 5) return 7'(lbl[a]);
    pos = a - 6;
    if (pos < 0 || pos >= DIGITS) return 7'h20;
    p = 10 ** (DIGITS - 1 - pos);
    d = (v / p) % 10;
    if (pos != DIGITS - 1 && v < p) return 7'h20;
    return 7'(8'h30 + d);
  endfunction

  // Driver tasks (all called at a negedge)
  task automatic read_cell(input logic [11:0] a, output logic [6:0] c);
    char_xy = a;
    @(negedge clk);
    c = char_code;
  endtask

  task automatic check_line(input string tag);
    logic [6:0] c;
    for (int a = 0; a < 16; a++) exp_q.push_back(exp_char(a, model_val));
    for (int a = 0; a < 16; a++) begin
      read_cell(12'(a), c);
      check(tag, {25'd0, c}, {25'd0, exp_q.pop_front()});
    end
  endtask

  // Issues an update and returns at the negedge where update_done is high.
  task automatic run_update(input int val);
    int n;
    score_in = SCORE_W'(val);
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    model_val = val;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_len", n, BUSY_CYCLES);
    check("done_pulse", {31'd0, update_done}, 1);
  endtask

  task automatic update_and_check(input int val, input string tag);
    run_update(val);
    @(negedge clk);
    check("done_one_cycle", {31'd0, update_done}, 0);
    check_line(tag);
  endtask

  initial begin
    int pulses;
    logic [6:0] c;
    logic [11:0] a;

    repeat (3) @(negedge clk);
    check("rst_char_code", {25'd0, char_code}, 32'h20);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, update_done}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_line("reset_line");

    update_and_check(1234, "line_1234");
    update_and_check(7, "line_7");
    update_and_check(0, "line_0");
    update_and_check(16383, "line_sat");

    // Back-to-back: second request lands in the update_done cycle.
    run_update(55);
    run_update(8765);
    @(negedge clk);
    check_line("line_b2b");

    // Request during busy is dropped.
    score_in = SCORE_W'(42);
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    model_val = 42;
    repeat (4) @(negedge clk);
    score_in = SCORE_W'(500);
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (update_done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("drop_pulses", pulses, 1);
    check("drop_busy", {31'd0, busy}, 0);
    check_line("line_drop");

    // Reset in the middle of CONVERT.
    score_in = SCORE_W'(9999);
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, update_done}, 0);
    check("midrst_code", {25'd0, char_code}, 32'h20);
    @(negedge clk);
    rst_n = 1'b1;
    model_val = 0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (update_done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("midrst_pulses", pulses, 0);
    check_line("line_midrst");

    // Random updates and random addresses.
    for (int k = 0; k < 8; k++) update_and_check(int'($urandom_range(0, 16383)), "line_rand");
    for (int k = 0; k < 20; k++) begin
      a = 12'($urandom_range(0, 4095));
      if (k < 10) a = 12'($urandom_range(0, 15));
      read_cell(a, c);
      check("rand_addr", {25'd0, c}, {25'd0, exp_char(int'(a), model_val)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
